// File: rtl/tx_mem_arbiter_pkg.sv
// rtl/tx_mem_arbiter_pkg.sv - shared constants and types for the TX RAM arbiter
package tx_mem_pkg;

    localparam int TX_MEM_ADDR_W = 10;
    localparam int TX_MEM_DATA_W = 32;
    localparam int TX_MEM_BE_W   = 4;
    localparam int TX_MEM_DEPTH  = 1024;

    typedef struct packed {
        logic [TX_MEM_ADDR_W-1:0] address;
        logic [TX_MEM_BE_W-1:0]   byteenable;
        logic                     read;
        logic                     write;
        logic [TX_MEM_DATA_W-1:0] writedata;
    } tx_mem_req_t;

    typedef enum logic [0:0] {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED1  = 1'b1
    } tx_arb_lock_state_e;

endpackage

// File: rtl/tx_mem_arbiter_if.sv
// rtl/tx_mem_arbiter_if.sv - requester Avalon-MM bus and RAM pin bundle
interface tx_mem_arbiter_if #(
    parameter int ADDR_W = tx_mem_pkg::TX_MEM_ADDR_W,
    parameter int DATA_W = tx_mem_pkg::TX_MEM_DATA_W,
    parameter int BE_W   = tx_mem_pkg::TX_MEM_BE_W
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

interface tx_mem_ram_if #(
    parameter int ADDR_W = tx_mem_pkg::TX_MEM_ADDR_W,
    parameter int DATA_W = tx_mem_pkg::TX_MEM_DATA_W,
    parameter int BE_W   = tx_mem_pkg::TX_MEM_BE_W
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, byteenable, chipselect, write, writedata, clken,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, clken,
        output readdata
    );
endinterface

// File: rtl/tx_mem_arbiter_rr_arb2.sv
// rtl/tx_mem_arbiter_rr_arb2.sv - two-way round-robin grant with last-grant register
module tx_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);
    logic       r_last_grant;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = i_req;
        if (i_req[0] && i_req[1]) begin
            w_grant = r_last_grant ? 2'b01 : 2'b10;
        end
    end

    // Every grant is an accepted access, so the pointer follows the grant directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_grant[1]) begin
            r_last_grant <= 1'b1;
        end else if (w_grant[0]) begin
            r_last_grant <= 1'b0;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/tx_mem_arbiter.sv
// rtl/tx_mem_arbiter.sv - two-requester arbiter for the shared TX RAM; TX_ARB_LOCK_EN adds requester-1 lock
module tx_mem_arbiter
    import tx_mem_pkg::*;
#(
    parameter int ADDR_W = TX_MEM_ADDR_W,
    parameter int DATA_W = TX_MEM_DATA_W,
    parameter int BE_W   = TX_MEM_BE_W
) (
    input  logic                clk,
    input  logic                reset,
    tx_mem_arbiter_if.slave     m0,
    tx_mem_arbiter_if.slave     m1,
    input  logic                m1_lock,
    tx_mem_ram_if.master        mem
);
    tx_mem_req_t w_req0;
    tx_mem_req_t w_req1;
    tx_mem_req_t w_sel;
    logic        w_act0;
    logic        w_act1;
    logic        w_locked;
    logic [1:0]  w_req;
    logic [1:0]  w_grant;
    logic        r_rvalid0;
    logic        r_rvalid1;

    assign w_req0 = '{address: m0.address, byteenable: m0.byteenable, read: m0.read,
                      write: m0.write, writedata: m0.writedata};
    assign w_req1 = '{address: m1.address, byteenable: m1.byteenable, read: m1.read,
                      write: m1.write, writedata: m1.writedata};

    assign w_act0 = m0.read | m0.write;
    assign w_act1 = m1.read | m1.write;

`ifdef TX_ARB_LOCK_EN
    localparam logic [0:0] S_UNLOCKED = 1'(ARB_UNLOCKED);
    localparam logic [0:0] S_LOCKED1  = 1'(ARB_LOCKED1);

    logic [0:0] r_lock_state;

    // The lock releases in the same cycle m1_lock drops, so requester 0 can win that cycle.
    assign w_locked = (r_lock_state == S_LOCKED1) && m1_lock;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_state <= S_UNLOCKED;
        end else begin
            case (r_lock_state)
                S_UNLOCKED: if (w_grant[1] && m1_lock) r_lock_state <= S_LOCKED1;
                S_LOCKED1:  if (!m1_lock)              r_lock_state <= S_UNLOCKED;
                default:                               r_lock_state <= S_UNLOCKED;
            endcase
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = m1_lock;
    assign w_locked      = 1'b0;
`endif

    assign w_req = {w_act1 & ~reset, w_act0 & ~reset & ~w_locked};

    tx_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .i_req   (w_req),
        .o_grant (w_grant)
    );

    always_comb begin
        w_sel = w_req0;
        if (w_grant[1]) begin
            w_sel = w_req1;
        end
    end

    assign mem.address    = w_sel.address[ADDR_W-1:0];
    assign mem.byteenable = w_sel.byteenable[BE_W-1:0];
    assign mem.writedata  = w_sel.writedata[DATA_W-1:0];
    assign mem.chipselect = |w_grant;
    assign mem.write      = (|w_grant) & w_sel.write;
    assign mem.clken      = ~reset;

    assign m0.waitrequest = reset | (w_act0 & ~w_grant[0]);
    assign m1.waitrequest = reset | (w_act1 & ~w_grant[1]);

    // Read+write together is a write, so it never raises readdatavalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_grant[0] & m0.read & ~m0.write;
            r_rvalid1 <= w_grant[1] & m1.read & ~m1.write;
        end
    end

    assign m0.readdatavalid = r_rvalid0 & ~reset;
    assign m1.readdatavalid = r_rvalid1 & ~reset;
    assign m0.readdata      = mem.readdata[DATA_W-1:0];
    assign m1.readdata      = mem.readdata[DATA_W-1:0];

endmodule

// File: doc/tx_mem_arbiter.md
Name: tx_mem_arbiter

Overview:
- Two-requester arbiter sharing one single-port 1024x32 on-chip RAM in the TX subsystem.
  - Requester 0: host/CPU Avalon-MM master.
  - Requester 1: TX symbol streamer.
- Round-robin grant; at most one RAM access per cycle.
- Per-requester Avalon-MM slave interface with waitrequest and readdatavalid.
- Drives the RAM's address/byteenable/chipselect/write/writedata/clken pins and returns its unregistered q.

Parameters:
- ADDR_W, 10, RAM word-address width (1024 words)
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)

Ports:
- clk  in  1  single clock for arbiter and RAM
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  requester 0 word address
- m0_byteenable  in  BE_W  requester 0 byte lanes
- m0_read  in  1  requester 0 read request
- m0_write  in  1  requester 0 write request
- m0_writedata  in  DATA_W  requester 0 write data
- m0_waitrequest  out  1  requester 0 stall
- m0_readdata  out  DATA_W  requester 0 read data
- m0_readdatavalid  out  1  requester 0 read data valid
- m1_*  same eight signals as m0_*, for requester 1
- m1_lock  in  1  hold grant (only with TX_ARB_LOCK_EN; otherwise ignored)
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  BE_W  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_clken  out  1  to RAM clock enable
- mem_readdata  in  DATA_W  from RAM q (unregistered output; address registered inside RAM)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Request definition: req_n = mn_read | mn_write.
- Grant (combinational):
  - Only one requester active: that requester is granted.
  - Both active: the requester other than last_grant wins.
  - No requester active: no grant.
- Waitrequest: mn_waitrequest = req_n & ~grant_n, combinational. A request is accepted in the cycle it is granted. Requesters hold their signals stable while waitrequest is high (Avalon rule).
- Issue, same cycle as grant:
  - mem_chipselect = 1.
  - mem_write = granted write.
  - address, byteenable and writedata are muxed from the granted requester.
  - With no grant, mem_chipselect = 0 and mem_write = 0.
- last_grant: registered; updates to the granted index on every accepted access.
- Read latency is exactly 1 cycle:
  - rvalid_n register is set in the cycle after an accepted read.
  - mn_readdatavalid = rvalid_n.
  - mn_readdata = mem_readdata, passed through unregistered.
  - The next access may issue in the same cycle as the returning data (full pipelining: back-to-back reads give 1 word per cycle).
- mn_read and mn_write both high: treated as a write; no readdatavalid is produced.
- Write then read of the same address on consecutive cycles: the read returns the new data.
- mem_clken = ~reset.
- Reset values:
  - last_grant = 1, so requester 0 wins the first contention.
  - rvalid_0 = rvalid_1 = 0.
  - Lock FSM in UNLOCKED.
- During reset:
  - m0_waitrequest and m1_waitrequest are forced high.
  - mem_chipselect = 0.
  - readdatavalid outputs = 0.
- Reset mid-operation: an in-flight readdatavalid is discarded. Requests still held after reset are re-arbitrated from the reset state.

Optional Feature:
- Macro: TX_ARB_LOCK_EN.
- Defined: a 2-state FSM, UNLOCKED and LOCKED1.
  - UNLOCKED -> LOCKED1 when requester 1 is granted with m1_lock = 1.
  - In LOCKED1, requester 1 has absolute priority and requester 0 is stalled, even if requester 1 is idle.
  - LOCKED1 -> UNLOCKED on the first cycle m1_lock = 0.
  - Reset -> UNLOCKED.
- Undefined: m1_lock is ignored, no FSM is built, and arbitration is pure round-robin.

Decomposition:
- Package tx_mem_pkg holds:
  - constants TX_MEM_ADDR_W = 10, TX_MEM_DATA_W = 32, TX_MEM_BE_W = 4, TX_MEM_DEPTH = 1024;
  - typedef tx_mem_req_t as a struct {address, byteenable, read, write, writedata};
  - enum tx_arb_lock_state_e.
- One natural sub-module: tx_rr_arb2, the 2-way round-robin grant logic plus the last_grant register. Mux, read-valid pipeline and lock FSM stay in the top module.

Test Plan:
- Reset for 3 cycles, then idle: all waitrequest high during reset; mem_chipselect = 0 and readdatavalid = 0 throughout.
- m0 writes 0xDEADBEEF to address 0x005 (byteenable = 0xF), next cycle reads 0x005: waitrequest low both cycles; m0_readdatavalid = 1 one cycle later with data 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 read continuously from addresses 0x010 and 0x3FF: grants alternate 0,1,0,1 starting with m0; each requester is stalled every other cycle; readdatavalid alternates one cycle after each grant.
- m1 writes 0x000000AA to address 0x020 with byteenable = 0x1 over a preloaded 0x11223344, then reads: result 0x112233AA.
- With TX_ARB_LOCK_EN: m1 is granted with m1_lock = 1, then issues 4 reads while m0 requests: m0_waitrequest stays high until the first cycle m1_lock = 0, then m0 is granted. Without the macro, grants alternate.
- Assert reset in the cycle after an accepted m0 read: m0_readdatavalid stays 0; after reset, a contending m0/m1 pair gives the grant to m0.
